// File: rtl/mul_seq_param.sv
// Parametrised sequential shift-add multiplier (unsigned/signed per request) using an external adder.
// Optional build macro MUL_EARLY_EXIT_EN: finish RUN early once the remaining multiplier bits are zero.
module mul_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    input  logic               start,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] sum_in_a,
    output logic [2*WIDTH-1:0] sum_in_b,
    input  logic [2*WIDTH-1:0] sum_out
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P = PW'(1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic            last_iter;

    // Magnitudes for operand load; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
    always_comb begin
        a_abs = (signed_i && a_i[WIDTH-1]) ? (~a_i + ONE_W) : a_i;
        b_abs = (signed_i && b_i[WIDTH-1]) ? (~b_i + ONE_W) : b_i;
    end

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt == CW'(WIDTH - 1)) || (b_reg == '0);
`else
    assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        sum_in_a   = '0;
        sum_in_b   = '0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (b_reg[0]) begin
                    sum_in_a = acc;
                    sum_in_b = a_reg;
                end
                if (last_iter) state_next = FIX;
            end
            FIX: begin
                if (neg) begin
                    sum_in_a = ~acc;
                    sum_in_b = ONE_P;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= {{WIDTH{1'b0}}, a_abs};
                        b_reg <= b_abs;
                        acc   <= '0;
                        cnt   <= '0;
                        neg   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (b_reg[0]) acc <= sum_out;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CW'(1);
                end
                FIX: begin
                    result <= neg ? sum_out : acc;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_param.sv
// Self-checking bench for mul_seq_param: WIDTH=8 and WIDTH=16 instances, each with its own adder.
module tb_mul_seq_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        sg8 = 1'b0, st8 = 1'b0;
    logic [15:0] result8, sa8, sb8, so8;
    logic        busy8, done8;

    logic [15:0] a16 = '0, b16 = '0;
    logic        sg16 = 1'b0, st16 = 1'b0;
    logic [31:0] result16, sa16, sb16, so16;
    logic        busy16, done16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign so8  = sa8 + sb8;
    assign so16 = sa16 + sb16;

    mul_seq_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a_i(a8), .b_i(b8), .signed_i(sg8), .start(st8),
        .result(result8), .busy(busy8), .done(done8),
        .sum_in_a(sa8), .sum_in_b(sb8), .sum_out(so8)
    );

    mul_seq_param #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .a_i(a16), .b_i(b16), .signed_i(sg16), .start(st16),
        .result(result16), .busy(busy16), .done(done16),
        .sum_in_a(sa16), .sum_in_b(sb16), .sum_out(so16)
    );

    // Reference product: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [31:0] exp_prod(input logic [15:0] a, input logic [15:0] b,
                                             input logic sgn, input int w);
        longint sa, sb, p;
        if (w == 8) begin
            sa = longint'(a[7:0]);
            sb = longint'(b[7:0]);
            if (sgn && a[7]) sa = sa - 256;
            if (sgn && b[7]) sb = sb - 256;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            if (sgn && a[15]) sa = sa - 65536;
            if (sgn && b[15]) sb = sb - 65536;
        end
        p = sa * sb;
        if (w == 8) return {16'b0, p[15:0]};
        return p[31:0];
    endfunction

    function automatic int exp_busy(input logic [15:0] b, input logic sgn, input int w);
`ifdef MUL_EARLY_EXIT_EN
        longint mag;
        int k;
        if (w == 8) begin
            mag = longint'(b[7:0]);
            if (sgn && b[7]) mag = 256 - mag;
        end else begin
            mag = longint'(b);
            if (sgn && b[15]) mag = 65536 - mag;
        end
        k = 0;
        while (mag > 0) begin
            k++;
            mag = mag / 2;
        end
        return ((k + 1 < w) ? k + 1 : w) + 1;
`else
        if (sgn) return w + 1;
        return w + 1 + int'(b[0]) - int'(b[0]);
`endif
    endfunction

    // Drives one operation; optionally pulses start (a=9,b=9) at busy cycle `poke`.
    task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input int poke,
                          output logic [31:0] res, output int busy_n,
                          output bit done_ok, output bit tmo);
        int n;
        @(negedge clk);
        if (wide) begin a16 = a; b16 = b; sg16 = sgn; st16 = 1'b1; end
        else begin a8 = a[7:0]; b8 = b[7:0]; sg8 = sgn; st8 = 1'b1; end
        @(negedge clk);
        st8 = 1'b0; st16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        busy_n = 0; done_ok = 1'b1; tmo = 1'b0; res = '0; n = 0;
        while ((wide ? busy16 : busy8) && n < 100) begin
            busy_n++;
            if (wide ? done16 : done8) done_ok = 1'b0;
            if (n == poke) begin
                if (wide) begin a16 = 16'd9; b16 = 16'd9; st16 = 1'b1; end
                else begin a8 = 8'd9; b8 = 8'd9; st8 = 1'b1; end
            end else begin
                st8 = 1'b0; st16 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        st8 = 1'b0; st16 = 1'b0;
        if (n >= 100) begin
            tmo = 1'b1;
        end else begin
            if (!(wide ? done16 : done8)) done_ok = 1'b0;
            res = wide ? result16 : {16'b0, result8};
            @(negedge clk);
            if (wide ? done16 : done8) done_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++; if (busy8 !== 1'b0)    begin fails++; $display("FAIL reset_busy8 got %b want 0", busy8); end
        tests++; if (done8 !== 1'b0)    begin fails++; $display("FAIL reset_done8 got %b want 0", done8); end
        tests++; if (result8 !== 16'h0) begin fails++; $display("FAIL reset_result8 got %h want 0", result8); end
        tests++; if (busy16 !== 1'b0)   begin fails++; $display("FAIL reset_busy16 got %b want 0", busy16); end
        tests++; if (done16 !== 1'b0)   begin fails++; $display("FAIL reset_done16 got %b want 0", done16); end
        tests++; if (result16 !== 32'h0) begin fails++; $display("FAIL reset_result16 got %h want 0", result16); end
    endtask

    task automatic test_directed();
        logic [15:0] av [6] = '{16'd255, 16'd255, 16'hFD, 16'h80, 16'd127, 16'd5};
        logic [15:0] bv [6] = '{16'd255, 16'd0,   16'd5,  16'h80, 16'h80,  16'd3};
        logic        sv [6] = '{1'b0,    1'b0,    1'b1,   1'b1,   1'b1,    1'b0};
        logic [31:0] wantv [6] = '{32'hFE01, 32'h0, 32'hFFF1, 32'h4000, 32'hC080, 32'd15};
        logic [31:0] res;
        int bn, eb;
        bit dok, tmo;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, av[i], bv[i], sv[i], -1, res, bn, dok, tmo);
            eb = exp_busy(bv[i], sv[i], 8);
            tests++; if (tmo) begin fails++; $display("FAIL dir%0d_timeout busy never fell", i); end
            tests++; if (res !== wantv[i]) begin fails++; $display("FAIL dir%0d_result got %h want %h", i, res, wantv[i]); end
            tests++; if (bn !== eb) begin fails++; $display("FAIL dir%0d_busy_len got %0d want %0d", i, bn, eb); end
            tests++; if (!dok) begin fails++; $display("FAIL dir%0d_done_pulse got bad want single pulse at busy fall", i); end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic        s;
        logic [31:0] res, want;
        int bn, eb, w;
        bit dok, tmo;
        for (int i = 0; i < 50; i++) begin
            w = (i < 40) ? 8 : 16;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 5))
                0: b = '0;
                1: a = (w == 8) ? 16'h80 : 16'h8000;
                2: b = (w == 8) ? 16'hFF : 16'hFFFF;
                3: b = 16'($urandom_range(0, 7));
                default: ;
            endcase
            s = 1'($urandom);
            run_op(w == 16, a, b, s, -1, res, bn, dok, tmo);
            want = exp_prod(a, b, s, w);
            eb = exp_busy(b, s, w);
            tests++; if (tmo || res !== want) begin fails++; $display("FAIL rnd%0d_result w=%0d a=%h b=%h s=%b got %h want %h", i, w, a, b, s, res, want); end
            tests++; if (bn !== eb) begin fails++; $display("FAIL rnd%0d_busy_len got %0d want %0d", i, bn, eb); end
            tests++; if (!dok) begin fails++; $display("FAIL rnd%0d_done_pulse got bad want single pulse", i); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] res;
        int bn;
        bit dok, tmo;
        run_op(1'b0, 16'd7, 16'd6, 1'b0, 3, res, bn, dok, tmo);
        tests++; if (tmo || res !== 32'd42) begin fails++; $display("FAIL busy_start_result got %0d want 42", res); end
        tests++; if (bn !== exp_busy(16'd6, 1'b0, 8)) begin fails++; $display("FAIL busy_start_len got %0d want %0d", bn, exp_busy(16'd6, 1'b0, 8)); end
        tests++; if (!dok) begin fails++; $display("FAIL busy_start_done got bad want single pulse"); end
        @(negedge clk);
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL busy_start_restart got busy=%b want 0", busy8); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int bn;
        bit dok, tmo, saw_done;
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; sg8 = 1'b0; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy8); end
        tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL midrst_done got %b want 0", done8); end
        tests++; if (result8 !== 16'h0) begin fails++; $display("FAIL midrst_result got %h want 0", result8); end
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) saw_done = 1'b1;
        end
        tests++; if (saw_done) begin fails++; $display("FAIL midrst_quiet got activity want none"); end
        // rst and start together: the request must be dropped
        a8 = 8'd5; b8 = 8'd5; st8 = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; st8 = 1'b0;
        @(negedge clk);
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL rst_start_busy got %b want 0", busy8); end
        run_op(1'b0, 16'd12, 16'd11, 1'b0, -1, res, bn, dok, tmo);
        tests++; if (tmo || res !== 32'd132) begin fails++; $display("FAIL midrst_next_result got %0d want 132", res); end
        tests++; if (bn !== exp_busy(16'd11, 1'b0, 8)) begin fails++; $display("FAIL midrst_next_len got %0d want %0d", bn, exp_busy(16'd11, 1'b0, 8)); end
    endtask

    task automatic test_width16();
        logic [31:0] res;
        int bn;
        bit dok, tmo;
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, -1, res, bn, dok, tmo);
        tests++; if (tmo || res !== 32'hFFFE0001) begin fails++; $display("FAIL w16_umax_result got %h want fffe0001", res); end
        tests++; if (bn !== 17) begin fails++; $display("FAIL w16_umax_len got %0d want 17", bn); end
        tests++; if (!dok) begin fails++; $display("FAIL w16_umax_done got bad want single pulse"); end
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, -1, res, bn, dok, tmo);
        tests++; if (tmo || res !== 32'h00000001) begin fails++; $display("FAIL w16_sneg1_result got %h want 00000001", res); end
        tests++; if (bn !== exp_busy(16'hFFFF, 1'b1, 16)) begin fails++; $display("FAIL w16_sneg1_len got %0d want %0d", bn, exp_busy(16'hFFFF, 1'b1, 16)); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        a8 = 8'd13; b8 = 8'd17; sg8 = 1'b0; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        tests++; if (n >= 100 || result8 !== 16'd221) begin fails++; $display("FAIL b2b_first_result got %0d want 221", result8); end
        tests++; if (done8 !== 1'b1) begin fails++; $display("FAIL b2b_first_done got %b want 1", done8); end
        a8 = 8'hF6; b8 = 8'd9; sg8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        tests++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin fails++; $display("FAIL b2b_restart got busy=%b done=%b want busy=1 done=0", busy8, done8); end
        n = 0;
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        tests++; if (n >= 100 || result8 !== 16'hFFA6) begin fails++; $display("FAIL b2b_second_result got %h want ffa6", result8); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid_op();
        test_width16();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
